adder_tree_sr: RTL and testbench

Parametrised, fully pipelined signed adder tree for the DCT datapath. It sums N_IN two's-complement samples, applies a round-and-shift scaling and saturates the result to OUT_W bits. It generalises the fixed 8×14-bit → 12-bit adder with:
- configurable input count and widths
- valid qualification
- runtime rounding mode
- a sticky saturation flag
It sits between the coefficient multipliers and the DCT output register.

---
 rtl/adder_tree_sr_pkg.sv | 38 +++
 rtl/adder_tree_sr_round_sat.sv | 43 ++++
 rtl/adder_tree_sr.sv | 122 ++++++++++++
 tb/tb_adder_tree_sr.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_sr_pkg.sv
// Shared helpers for the adder_tree_sr block: width derivation and saturation limits.
package adder_tree_sr_pkg;

   // Largest input count the tree is sized for.
   localparam int unsigned MaxInputs = 32;

   // Ceiling log2 for elaboration-time width derivation.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r++;
      end
      return r;
   endfunction

   // Full-precision sum width: one growth bit per tree level.
   function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned n_in);
      return in_w + clog2(n_in);
   endfunction

   // Output width of tree level lvl (0-based): operands of in_w+lvl bits plus a carry bit.
   function automatic int unsigned lvl_width(input int unsigned in_w, input int unsigned lvl);
      return in_w + lvl + 1;
   endfunction

   function automatic longint sat_max(input int unsigned out_w);
      return (longint'(1) << (out_w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int unsigned out_w);
      return -(longint'(1) << (out_w - 1));
   endfunction

endpackage

// File: rtl/adder_tree_sr_round_sat.sv
// Combinational round-half-up / arithmetic shift / saturate of the full-precision sum.
module round_sat
   import adder_tree_sr_pkg::*;
#(
   parameter int unsigned SUM_W = 17,
   parameter int unsigned SHIFT = 3,
   parameter int unsigned OUT_W = 12
) (
   input  logic signed [SUM_W-1:0] sum_i,
   input  logic                    rnd_i,
   output logic [OUT_W-1:0]        val_o,
   output logic                    sat_o
);

   // One extra bit so that adding the rounding constant cannot wrap.
   localparam int unsigned ExtW = SUM_W + 1;
   // Half an output LSB; zero when SHIFT is 0, so rounding degenerates to a pass-through.
   localparam logic signed [ExtW-1:0] Half = ExtW'((longint'(1) << SHIFT) >> 1);

   logic signed [ExtW-1:0] ext;
   logic signed [ExtW-1:0] shifted;
   logic signed [63:0]     res;

   // Round, shift and clamp to the signed OUT_W range.
   always_comb begin
      ext = {sum_i[SUM_W-1], sum_i};
      if (rnd_i) begin
         ext = ext + Half;
      end
      shifted = ext >>> SHIFT;
      res     = 64'(shifted);
      sat_o   = 1'b0;
      val_o   = res[OUT_W-1:0];
      if (res > sat_max(OUT_W)) begin
         val_o = OUT_W'(sat_max(OUT_W));
         sat_o = 1'b1;
      end else if (res < sat_min(OUT_W)) begin
         val_o = OUT_W'(sat_min(OUT_W));
         sat_o = 1'b1;
      end
   end

endmodule

// File: rtl/adder_tree_sr.sv
// Pipelined signed adder tree with round/shift/saturate output stage and sticky saturation flag.
module adder_tree_sr
   import adder_tree_sr_pkg::*;
#(
   parameter int unsigned N_IN  = 8,
   parameter int unsigned IN_W  = 14,
   parameter int unsigned OUT_W = 12,
   parameter int unsigned SHIFT = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [N_IN*IN_W-1:0] din,
   input  logic                 rnd_en,
   input  logic                 clr_sat,
   output logic                 out_valid,
   output logic [OUT_W-1:0]     dout,
   output logic                 sat,
   output logic                 sat_sticky
);

   localparam int unsigned L    = clog2(N_IN);
   localparam int unsigned SumW = sum_width(IN_W, N_IN);

   if ((N_IN < 2) || (N_IN > MaxInputs) || ((1 << L) != N_IN)) begin : g_bad_n_in
      $fatal(1, "adder_tree_sr: N_IN must be a power of two in 2..32");
   end
   if (SHIFT >= SumW) begin : g_bad_shift
      $fatal(1, "adder_tree_sr: SHIFT must be below SUM_W");
   end

   logic [L-1:0] vld_q;
   logic [L-1:0] rnd_q;

   // Valid and rounding mode ride alongside the tree levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         rnd_q <= '0;
      end else begin
         vld_q <= (vld_q << 1) | L'(in_valid);
         rnd_q <= (rnd_q << 1) | L'(rnd_en);
      end
   end

   for (genvar j = 0; j < L; j++) begin : g_lvl
      localparam int unsigned NOut = N_IN >> (j + 1);
      localparam int unsigned WOut = lvl_width(IN_W, j);
      for (genvar k = 0; k < NOut; k++) begin : g_node
         logic signed [WOut-2:0] a;
         logic signed [WOut-2:0] b;
         logic signed [WOut-1:0] sum_q;
         if (j == 0) begin : g_src_in
            assign a = din[(2*k)*IN_W +: IN_W];
            assign b = din[(2*k+1)*IN_W +: IN_W];
         end else begin : g_src_lvl
            assign a = g_lvl[j-1].g_node[2*k].sum_q;
            assign b = g_lvl[j-1].g_node[2*k+1].sum_q;
         end
         // Sign-extended pairwise add; data loads every cycle, validity is tracked separately.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sum_q <= '0;
            end else begin
               sum_q <= WOut'(a) + WOut'(b);
            end
         end
      end
   end

   logic signed [SumW-1:0] tree_sum;
   logic [OUT_W-1:0]       rs_val;
   logic                   rs_sat;

   assign tree_sum = g_lvl[L-1].g_node[0].sum_q;

   round_sat #(
      .SUM_W(SumW),
      .SHIFT(SHIFT),
      .OUT_W(OUT_W)
   ) u_round_sat (
      .sum_i(tree_sum),
      .rnd_i(rnd_q[L-1]),
      .val_o(rs_val),
      .sat_o(rs_sat)
   );

   logic             out_valid_q;
   logic [OUT_W-1:0] dout_q;
   logic             sat_q;
   logic             sat_sticky_q;
   logic             sat_sticky_d;

   // The sticky flag sets on the same edge the saturated beat is presented, so it is
   // already high while out_valid && sat are visible; a coincident clear loses.
   always_comb begin
      sat_sticky_d = (vld_q[L-1] & rs_sat) | (sat_sticky_q & ~clr_sat);
   end

   // Output stage: dout/sat update only with valid beats and hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         dout_q       <= '0;
         sat_q        <= 1'b0;
         sat_sticky_q <= 1'b0;
      end else begin
         out_valid_q  <= vld_q[L-1];
         sat_sticky_q <= sat_sticky_d;
         if (vld_q[L-1]) begin
            dout_q <= rs_val;
            sat_q  <= rs_sat;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign dout       = dout_q;
   assign sat        = sat_q;
   assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_adder_tree_sr.sv
// Self-checking bench for adder_tree_sr: arithmetic reference model plus directed literal checks.
module tb_adder_tree_sr;

   localparam int unsigned N_IN  = 8;
   localparam int unsigned IN_W  = 14;
   localparam int unsigned OUT_W = 12;
   localparam int unsigned SHIFT = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 in_valid;
   logic [N_IN*IN_W-1:0] din;
   logic                 rnd_en;
   logic                 clr_sat;
   logic                 out_valid;
   logic [OUT_W-1:0]     dout;
   logic                 sat;
   logic                 sat_sticky;

   adder_tree_sr #(
      .N_IN (N_IN),
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .SHIFT(SHIFT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .din       (din),
      .rnd_en    (rnd_en),
      .clr_sat   (clr_sat),
      .out_valid (out_valid),
      .dout      (dout),
      .sat       (sat),
      .sat_sticky(sat_sticky)
   );

   initial forever #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer sum of the samples, optional +half-LSB, floor shift, clamp.
   function automatic void ref_model(input logic [N_IN*IN_W-1:0] d, input bit r,
                                     output logic [OUT_W-1:0] od, output logic os);
      longint s;
      longint hi;
      longint lo;
      s  = 0;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      for (int k = 0; k < N_IN; k++) begin
         logic signed [IN_W-1:0] smp;
         smp = d[k*IN_W +: IN_W];
         s = s + longint'(smp);
      end
      if (r && SHIFT > 0) s = s + (longint'(1) << (SHIFT - 1));
      s = s >>> SHIFT;
      os = 1'b1;
      if (s > hi) od = OUT_W'(hi);
      else if (s < lo) od = OUT_W'(lo);
      else begin
         od = OUT_W'(s);
         os = 1'b0;
      end
   endfunction

   typedef struct {
      int               due;
      logic [OUT_W-1:0] d;
      logic             s;
   } exp_t;

   exp_t             exp_q[$];
   int               m_cnt    = 0;
   logic             m_ov     = 1'b0;
   logic [OUT_W-1:0] m_dout   = '0;
   logic             m_sat    = 1'b0;
   logic             m_sticky = 1'b0;

   // Model: a beat sampled on edge n is presented after edge n+3 (four registers deep).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_ov     = 1'b0;
         m_dout   = '0;
         m_sat    = 1'b0;
         m_sticky = 1'b0;
      end else begin
         exp_t e;
         m_cnt++;
         m_ov = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].due == m_cnt) begin
            e      = exp_q.pop_front();
            m_ov   = 1'b1;
            m_dout = e.d;
            m_sat  = e.s;
         end
         if (m_ov && m_sat) m_sticky = 1'b1;
         else if (clr_sat) m_sticky = 1'b0;
         if (in_valid) begin
            e.due = m_cnt + 3;
            ref_model(din, rnd_en, e.d, e.s);
            exp_q.push_back(e);
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("cyc.out_valid", 64'(out_valid), 64'(m_ov));
      chk("cyc.dout", 64'(dout), 64'(m_dout));
      chk("cyc.sat", 64'(sat), 64'(m_sat));
      chk("cyc.sat_sticky", 64'(sat_sticky), 64'(m_sticky));
   end

   typedef struct {
      logic [OUT_W-1:0] d;
      logic             s;
      int               cnt;
   } beat_t;

   beat_t got_q[$];
   int    edge_cnt = 0;

   always @(posedge clk) edge_cnt++;

   always @(negedge clk) begin
      if (out_valid) begin
         beat_t b;
         b.d   = dout;
         b.s   = sat;
         b.cnt = edge_cnt;
         got_q.push_back(b);
      end
   end

   task automatic send(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input bit r,
                       output int t0);
      @(negedge clk);
      for (int k = 0; k < N_IN; k++) din[k*IN_W +: IN_W] = (k % 2 == 0) ? a : b;
      in_valid = 1'b1;
      rnd_en   = r;
      t0       = edge_cnt;
   endtask

   // Bubbles carry random data to show that invalid slots cannot leak into results.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         rnd_en   = 1'($urandom);
         for (int k = 0; k < N_IN; k++) din[k*IN_W +: IN_W] = IN_W'($urandom);
      end
   endtask

   task automatic check_next(input string name, input logic [OUT_W-1:0] ed, input logic es,
                             output int cnt);
      int i;
      beat_t b;
      i = 0;
      while (got_q.size() == 0 && i < 20) begin
         @(negedge clk);
         #1;
         i++;
      end
      if (got_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no out_valid within 20 cycles, expected dout 0x%0h", name, ed);
         cnt = -1;
      end else begin
         b = got_q.pop_front();
         chk({name, ".dout"}, 64'(b.d), 64'(ed));
         chk({name, ".sat"}, 64'(b.s), 64'(es));
         cnt = b.cnt;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int tc;
      in_valid = 1'b0;
      din      = '0;
      rnd_en   = 1'b0;
      clr_sat  = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.dout", 64'(dout), 64'd0);
      chk("reset.sat_sticky", 64'(sat_sticky), 64'd0);
      idle(2);

      // 1: all -1, sum -8, rounds to -1; latency of four cycles.
      send(14'h3FFF, 14'h3FFF, 1'b1, t0);
      idle(1);
      check_next("t1", 12'hFFF, 1'b0, tc);
      chk("t1.latency", 64'(tc - t0), 64'd4);
      idle(3);

      // 2: positive and negative saturation.
      send(14'h1FFF, 14'h1FFF, 1'b1, t0);
      idle(1);
      check_next("t2.max", 12'h7FF, 1'b1, tc);
      chk("t2.sticky", 64'(sat_sticky), 64'd1);
      send(14'h2000, 14'h2000, 1'b1, t0);
      idle(1);
      check_next("t2.min", 12'h800, 1'b1, tc);
      idle(3);

      // 3: small sums.
      send(14'h0001, 14'h0001, 1'b1, t0);
      send(14'h0001, 14'h3FFF, 1'b1, t0);
      idle(1);
      check_next("t3.ones", 12'h001, 1'b0, tc);
      check_next("t3.zero", 12'h000, 1'b0, tc);
      idle(3);

      // 4: sum -4, rounding mode must stay with its own beat.
      send(14'h2AAA, 14'h1555, 1'b1, t0);
      send(14'h2AAA, 14'h1555, 1'b0, t0);
      idle(1);
      check_next("t4.rnd", 12'h000, 1'b0, tc);
      check_next("t4.trunc", 12'hFFF, 1'b0, tc);
      idle(3);

      // 5: six beats with bubbles.
      send(14'h0001, 14'h0001, 1'b1, t0);
      idle(1);
      send(14'h1FFF, 14'h2001, 1'b1, t0);
      send(14'h3FFF, 14'h3FFF, 1'b0, t0);
      idle(2);
      send(14'h0100, 14'h0100, 1'b1, t0);
      idle(1);
      send(14'h2000, 14'h2000, 1'b1, t0);
      send(14'h0010, 14'h3FF0, 1'b1, t0);
      idle(8);
      chk("t5.count", 64'(got_q.size()), 64'd6);
      check_next("t5.b0", 12'h001, 1'b0, tc);
      check_next("t5.b1", 12'h000, 1'b0, tc);
      check_next("t5.b2", 12'hFFF, 1'b0, tc);
      check_next("t5.b3", 12'h100, 1'b0, tc);
      check_next("t5.b4", 12'h800, 1'b1, tc);
      check_next("t5.b5", 12'h000, 1'b0, tc);

      // 6a: reset with three beats in flight after a saturated result.
      send(14'h1FFF, 14'h1FFF, 1'b1, t0);
      idle(1);
      check_next("t6.pre", 12'h7FF, 1'b1, tc);
      send(14'h0001, 14'h0001, 1'b1, t0);
      send(14'h0001, 14'h0001, 1'b1, t0);
      send(14'h0001, 14'h0001, 1'b1, t0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t6.rst.out_valid", 64'(out_valid), 64'd0);
      chk("t6.rst.dout", 64'(dout), 64'd0);
      chk("t6.rst.sat", 64'(sat), 64'd0);
      chk("t6.rst.sat_sticky", 64'(sat_sticky), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(8);
      chk("t6.flushed", 64'(got_q.size()), 64'd0);

      // 6b: clear coinciding with a saturated beat loses; a lone clear wins.
      send(14'h1FFF, 14'h1FFF, 1'b1, t0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr_sat = 1'b1;
      @(negedge clk);
      clr_sat = 1'b0;
      #1;
      chk("t6.coincide.out_valid", 64'(out_valid), 64'd1);
      chk("t6.coincide.sticky", 64'(sat_sticky), 64'd1);
      check_next("t6.coincide", 12'h7FF, 1'b1, tc);
      idle(2);
      @(negedge clk);
      clr_sat = 1'b1;
      @(negedge clk);
      clr_sat = 1'b0;
      #1;
      chk("t6.clear.sticky", 64'(sat_sticky), 64'd0);
      chk("t6.clear.dout_held", 64'(dout), 64'h7FF);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
